// File: rtl/find_string_pkg.sv
// Shared definitions for the string-find subsystem (text memory, loader, scanner).
//   state_e : scanner FSM encoding (idle / scanning / done pulse)
//   log2    : ceiling log2, used to size address and length fields
package find_string_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDone
   } state_e;

   // Ceiling log2; log2(1) = 0, log2(16) = 4, log2(5) = 3.
   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// Sliding window of the most recent text words compared against a pattern.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clear        : empty the window (new scan)
//   i_shift        : i_word is a valid text word this cycle
//   i_word         : incoming text word (newest)
//   i_pattern      : pattern word i at [i*Length +: Length], word 0 is the oldest in a match
//   i_pat_len      : number of active pattern words
//   o_match        : {last i_pat_len-1 stored words, i_word} equals the pattern
module pattern_window_cmp
   import find_string_pkg::*;
#(
   parameter int unsigned PatMax = 4,
   parameter int unsigned Length = 11,
   localparam int unsigned Plw = log2(PatMax + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_shift,
   input  logic [Length-1:0]        i_word,
   input  logic [PatMax*Length-1:0] i_pattern,
   input  logic [Plw-1:0]           i_pat_len,
   output logic                     o_match
);

   // The newest word is compared straight from i_word, so only PatMax-1 words need storing.
   localparam int unsigned WinDepth = (PatMax > 1) ? PatMax - 1 : 1;

   logic [Length-1:0] r_win [WinDepth];
   logic [Length-1:0] w_age [PatMax];
   logic [PatMax:0]   w_eq;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         for (int j = 0; j < WinDepth; j++) r_win[j] <= '0;
      end else if (i_shift) begin
         r_win[0] <= i_word;
         for (int j = 1; j < WinDepth; j++) r_win[j] <= r_win[j-1];
      end
   end

   // w_age[a] is the word seen a valid cycles ago (0 = current).
   always_comb begin
      w_age[0] = i_word;
      for (int a = 1; a < PatMax; a++) w_age[a] = r_win[a-1];
   end

   // One equality result per possible length keeps all indices constant.
   always_comb begin
      w_eq = '0;
      for (int l = 1; l <= PatMax; l++) begin
         w_eq[l] = 1'b1;
         for (int i = 0; i < l; i++) begin
            if (w_age[l-1-i] != i_pattern[i*Length +: Length]) w_eq[l] = 1'b0;
         end
      end
   end

   assign o_match = (32'(i_pat_len) <= PatMax) ? w_eq[i_pat_len] : 1'b0;

endmodule

// File: rtl/string_match_scanner.sv
// Scans the text memory for a pattern, counting every (overlapping) occurrence.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_start         : request a scan (accepted only when idle)
//   i_text_len      : number of valid text words, 0..Depth
//   i_pattern       : pattern words, word i at [i*Length +: Length]
//   i_pat_len       : number of active pattern words
//   o_read_addr     : memory read address (0 unless scanning)
//   i_mem_data      : memory read data, valid at the posedge after the address
//   o_busy          : scan in progress
//   o_done          : one-cycle completion pulse
//   o_found         : at least one match in the last scan
//   o_first_pos     : start index of the lowest match, 0 if none
//   o_match_count   : number of matches in the last scan
module string_match_scanner
   import find_string_pkg::*;
#(
   parameter int unsigned Depth  = 16,
   parameter int unsigned Length = 11,
   parameter int unsigned PatMax = 4,
   localparam int unsigned Aw  = log2(Depth),
   localparam int unsigned Plw = log2(PatMax + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [Aw:0]              i_text_len,
   input  logic [PatMax*Length-1:0] i_pattern,
   input  logic [Plw-1:0]           i_pat_len,
   output logic [Aw-1:0]            o_read_addr,
   input  logic [Length-1:0]        i_mem_data,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_found,
   output logic [Aw-1:0]            o_first_pos,
   output logic [Aw:0]              o_match_count
);

   state_e                   r_state, w_state_d;
   logic [Aw:0]              r_len, w_len_d;
   logic [PatMax*Length-1:0] r_pat, w_pat_d;
   logic [Plw-1:0]           r_pat_len, w_pat_len_d;
   logic [Aw-1:0]            r_addr, w_addr_d;
   logic                     r_valid, w_valid_d;
   logic [Aw:0]              r_idx, w_idx_d;
   logic                     r_found, w_found_d;
   logic [Aw-1:0]            r_first, w_first_d;
   logic [Aw:0]              r_count, w_count_d;

   logic w_clear;
   logic w_match;
   logic w_degen;
   logic w_hit;
   logic w_last;

   assign w_degen = (i_pat_len == '0) || (32'(i_pat_len) > PatMax) ||
                    (32'(i_pat_len) > 32'(i_text_len));
   // Word r_idx is at least the pattern length-1 deep into the text.
   assign w_hit   = w_match && (32'(r_idx) + 32'd1 >= 32'(r_pat_len));
   assign w_last  = (32'(r_idx) + 32'd1 == 32'(r_len));

   pattern_window_cmp #(
      .PatMax (PatMax),
      .Length (Length)
   ) u_window (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_clear),
      .i_shift   (r_valid && (r_state == StScan)),
      .i_word    (i_mem_data),
      .i_pattern (r_pat),
      .i_pat_len (r_pat_len),
      .o_match   (w_match)
   );

   always_comb begin
      w_state_d   = r_state;
      w_len_d     = r_len;
      w_pat_d     = r_pat;
      w_pat_len_d = r_pat_len;
      w_addr_d    = r_addr;
      w_valid_d   = r_valid;
      w_idx_d     = r_idx;
      w_found_d   = r_found;
      w_first_d   = r_first;
      w_count_d   = r_count;
      w_clear     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_len_d     = i_text_len;
               w_pat_d     = i_pattern;
               w_pat_len_d = i_pat_len;
               w_found_d   = 1'b0;
               w_first_d   = '0;
               w_count_d   = '0;
               w_idx_d     = '0;
               w_addr_d    = '0;
               w_clear     = 1'b1;
               if (w_degen) begin
                  w_state_d = StDone;
               end else begin
                  w_state_d = StScan;
                  w_valid_d = 1'b1;
               end
            end
         end
         StScan: begin
            if (r_valid) begin
               if (w_hit) begin
                  w_count_d = r_count + 1'b1;
                  if (!r_found) begin
                     w_found_d = 1'b1;
                     w_first_d = Aw'(32'(r_idx) + 32'd1 - 32'(r_pat_len));
                  end
               end
               w_idx_d = r_idx + 1'b1;
               if (w_last) begin
                  w_state_d = StDone;
                  w_valid_d = 1'b0;
                  w_addr_d  = '0;
               end else if (32'(r_addr) + 32'd1 < 32'(r_len)) begin
                  w_addr_d = r_addr + 1'b1;
               end
            end
         end
         StDone: w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_len     <= '0;
         r_pat     <= '0;
         r_pat_len <= '0;
         r_addr    <= '0;
         r_valid   <= 1'b0;
         r_idx     <= '0;
         r_found   <= 1'b0;
         r_first   <= '0;
         r_count   <= '0;
      end else begin
         r_state   <= w_state_d;
         r_len     <= w_len_d;
         r_pat     <= w_pat_d;
         r_pat_len <= w_pat_len_d;
         r_addr    <= w_addr_d;
         r_valid   <= w_valid_d;
         r_idx     <= w_idx_d;
         r_found   <= w_found_d;
         r_first   <= w_first_d;
         r_count   <= w_count_d;
      end
   end

   assign o_busy        = (r_state == StScan);
   assign o_done        = (r_state == StDone);
   assign o_read_addr   = (r_state == StScan) ? r_addr : '0;
   assign o_found       = r_found;
   assign o_first_pos   = r_first;
   assign o_match_count = r_count;

endmodule

// File: tb/tb_string_match_scanner.sv
// Directed bench for string_match_scanner with a negedge-registered text memory model.
module tb_string_match_scanner;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [4:0]  i_text_len;
   logic [43:0] i_pattern;
   logic [2:0]  i_pat_len;
   logic [3:0]  o_read_addr;
   logic [10:0] i_mem_data;
   logic        o_busy;
   logic        o_done;
   logic        o_found;
   logic [3:0]  o_first_pos;
   logic [4:0]  o_match_count;

   logic [10:0] mem [16];

   int total = 0;
   int bad   = 0;

   string_match_scanner u_dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_text_len    (i_text_len),
      .i_pattern     (i_pattern),
      .i_pat_len     (i_pat_len),
      .o_read_addr   (o_read_addr),
      .i_mem_data    (i_mem_data),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_found       (o_found),
      .o_first_pos   (o_first_pos),
      .o_match_count (o_match_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) i_mem_data <= mem[o_read_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_str(input string s);
      for (int i = 0; i < 16; i++) mem[i] = (i < s.len()) ? 11'(s[i]) : 11'h000;
   endtask

   function automatic logic [43:0] pack(input string s);
      logic [43:0] p;
      p = '0;
      for (int i = 0; i < s.len() && i < 4; i++) p[i*11 +: 11] = 11'(s[i]);
      return p;
   endfunction

   // Start a scan and follow it to done. Cycle 0 is the cycle after the start edge.
   task automatic run_scan(input string tag, input int len, input logic [43:0] pat,
                           input int plen, input bit hold, input bit exp_found,
                           input int exp_first, input int exp_count);
      bit degen;
      int exp_dc;
      int cyc;
      degen  = (plen == 0) || (plen > 4) || (plen > len);
      exp_dc = degen ? 0 : len;
      i_text_len = 5'(len);
      i_pattern  = pat;
      i_pat_len  = 3'(plen);
      i_start    = 1'b1;
      @(posedge i_clk); #1;
      if (!hold) i_start = 1'b0;
      cyc = 0;
      while (o_done !== 1'b1 && cyc < 40) begin
         chk({tag, ".busy"}, 32'(o_busy), 32'd1);
         chk({tag, ".addr"}, 32'(o_read_addr), (cyc < len - 1) ? 32'(cyc) : 32'(len - 1));
         @(posedge i_clk); #1;
         cyc++;
      end
      i_start = 1'b0;
      chk({tag, ".done_seen"}, 32'(o_done), 32'd1);
      chk({tag, ".latency"}, 32'(cyc), 32'(exp_dc));
      chk({tag, ".busy_at_done"}, 32'(o_busy), 32'd0);
      chk({tag, ".addr_at_done"}, 32'(o_read_addr), 32'd0);
      chk({tag, ".found"}, 32'(o_found), 32'(exp_found));
      chk({tag, ".first_pos"}, 32'(o_first_pos), 32'(exp_first));
      chk({tag, ".count"}, 32'(o_match_count), 32'(exp_count));
      @(posedge i_clk); #1;
      chk({tag, ".done_pulse"}, 32'(o_done), 32'd0);
      chk({tag, ".idle_busy"}, 32'(o_busy), 32'd0);
      chk({tag, ".held_count"}, 32'(o_match_count), 32'(exp_count));
      chk({tag, ".held_first"}, 32'(o_first_pos), 32'(exp_first));
   endtask

   initial begin
      bit saw_done;
      i_rst      = 1'b1;
      i_start    = 1'b0;
      i_text_len = '0;
      i_pattern  = '0;
      i_pat_len  = '0;
      load_str("");
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst.busy", 32'(o_busy), 32'd0);
      chk("rst.done", 32'(o_done), 32'd0);
      chk("rst.found", 32'(o_found), 32'd0);
      chk("rst.first", 32'(o_first_pos), 32'd0);
      chk("rst.count", 32'(o_match_count), 32'd0);
      chk("rst.addr", 32'(o_read_addr), 32'd0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      load_str("ABCABD");
      run_scan("t1", 6, pack("AB"), 2, 1'b0, 1'b1, 0, 2);

      load_str("AAAA");
      run_scan("t2", 4, pack("AA"), 2, 1'b0, 1'b1, 0, 3);

      // Degenerate lengths; results from t2 must be cleared.
      load_str("ABCD");
      run_scan("t4a", 3, pack("AB"), 0, 1'b0, 1'b0, 0, 0);
      run_scan("t4b", 4, pack("ABCD"), 5, 1'b0, 1'b0, 0, 0);
      run_scan("t4c", 3, pack("ABC"), 4, 1'b0, 1'b0, 0, 0);

      load_str("XYZ");
      run_scan("t3", 3, pack("Q"), 1, 1'b0, 1'b0, 0, 0);

      // Words differing only in the top bit must not match.
      load_str("");
      mem[0] = 11'h441;
      mem[1] = 11'h041;
      run_scan("tbit", 2, pack("A"), 1, 1'b0, 1'b1, 1, 1);

      load_str("ABCDEFGHIJKLWXYZ");
      run_scan("t5", 16, pack("WXYZ"), 4, 1'b0, 1'b1, 12, 1);

      // Reset during a scan: after the third edge of the scan.
      load_str("ABCABD");
      i_text_len = 5'd6;
      i_pattern  = pack("AB");
      i_pat_len  = 3'd2;
      i_start    = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("t6.pre_found", 32'(o_found), 32'd1);
      chk("t6.pre_count", 32'(o_match_count), 32'd1);
      chk("t6.pre_addr", 32'(o_read_addr), 32'd2);
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      chk("t6.rst_busy", 32'(o_busy), 32'd0);
      chk("t6.rst_done", 32'(o_done), 32'd0);
      chk("t6.rst_found", 32'(o_found), 32'd0);
      chk("t6.rst_first", 32'(o_first_pos), 32'd0);
      chk("t6.rst_count", 32'(o_match_count), 32'd0);
      chk("t6.rst_addr", 32'(o_read_addr), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge i_clk); #1;
         if (o_done === 1'b1) saw_done = 1'b1;
      end
      chk("t6.no_done", 32'(saw_done), 32'd0);

      // Start held high across the whole scan must not restart it.
      run_scan("t6h", 6, pack("AB"), 2, 1'b1, 1'b1, 0, 2);
      load_str("ABCABD");
      run_scan("t6f", 6, pack("BD"), 2, 1'b0, 1'b1, 4, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
